// File: rtl/gpr_pkg.sv
// Shared defaults and index types for the bypassing register file.
package gpr_pkg;

    localparam int GPR_DATA_WIDTH = 32;
    localparam int GPR_ADDR_WIDTH = 5;

    typedef logic [GPR_ADDR_WIDTH-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits tracking in-flight producers for RAW detection.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] num_write,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  set_hit;
    logic                  clr_hit;
    logic                  inc;
    logic                  dec;
    logic                  fwd_rs;
    logic                  fwd_rt;

    assign set_hit = issue_valid && (issue_rd != ADDR_WIDTH'(REG_ZERO));
    assign clr_hit = reg_write && (num_write != ADDR_WIDTH'(REG_ZERO));

    // Set is applied after clear so a new producer wins on a shared index.
    always_comb begin
        busy_d = busy_q;
        if (clr_hit) busy_d[num_write] = 1'b0;
        if (set_hit) busy_d[issue_rd]  = 1'b1;
    end

    assign inc = set_hit && !busy_q[issue_rd];
    assign dec = clr_hit && busy_q[num_write] &&
                 !(set_hit && (issue_rd == num_write));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q <= busy_d;
            unique case (1'b1)
                inc && !dec: count_q <= count_q + CNT_ONE;
                dec && !inc: count_q <= count_q - CNT_ONE;
                default:     count_q <= count_q;
            endcase
        end
    end

    assign fwd_rs = (BYPASS != 0) && reg_write && (num_write == rs);
    assign fwd_rt = (BYPASS != 0) && reg_write && (num_write == rt);

    assign rs_busy    = busy_q[rs] && !fwd_rs;
    assign rt_busy    = busy_q[rt] && !fwd_rt;
    assign busy_count = count_q;

endmodule

// File: rtl/gpr_bypass_sb.sv
// Two-read/one-write register file with r0 hardwired to zero,
// optional writeback bypass and a RAW busy scoreboard.
module gpr_bypass_sb
    import gpr_pkg::*;
#(
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] num_write,
    input  logic [DATA_WIDTH-1:0] data_write,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en;
    logic                  fwd_ok;

    assign wr_en  = reg_write && (num_write != ADDR_WIDTH'(REG_ZERO));
    // Forwarding is suppressed in reset so every read sees zero.
    assign fwd_ok = (BYPASS != 0) && wr_en && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[num_write] <= data_write;
        end
    end

    always_comb begin
        a = regs[rs];
        unique case (1'b1)
            rs == ADDR_WIDTH'(REG_ZERO):  a = '0;
            fwd_ok && (num_write == rs):  a = data_write;
            default:                      a = regs[rs];
        endcase
    end

    always_comb begin
        b = regs[rt];
        unique case (1'b1)
            rt == ADDR_WIDTH'(REG_ZERO):  b = '0;
            fwd_ok && (num_write == rt):  b = data_write;
            default:                      b = regs[rt];
        endcase
    end

    gpr_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
    ) u_sb (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .reg_write   (reg_write),
        .num_write   (num_write),
        .rs          (rs),
        .rt          (rt),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .busy_count  (busy_count)
    );

endmodule

// File: tb/tb_gpr_bypass_sb.sv
// Directed bench for gpr_bypass_sb: bypass and non-bypass builds side by side.
module tb_gpr_bypass_sb;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs = '0, rt = '0, num_write = '0, issue_rd = '0;
    logic        reg_write = 1'b0, issue_valid = 1'b0;
    logic [31:0] data_write = '0;

    logic [31:0] a1, b1, a0, b0;
    logic        rsb1, rtb1, rsb0, rtb0;
    logic [5:0]  cnt1, cnt0;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: plain arrays
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    always #5 clock = ~clock;

    gpr_bypass_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) u_byp (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .a(a1), .b(b1),
        .reg_write(reg_write), .num_write(num_write), .data_write(data_write),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs_busy(rsb1), .rt_busy(rtb1), .busy_count(cnt1));

    gpr_bypass_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) u_nob (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .a(a0), .b(b0),
        .reg_write(reg_write), .num_write(num_write), .data_write(data_write),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs_busy(rsb0), .rt_busy(rtb0), .busy_count(cnt0));

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (reg_write && num_write != 0) begin
                m_regs[num_write] = data_write;
                m_busy[num_write] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp);
        if (idx == 0 || reset) return 32'h0;
        if (byp && reg_write && num_write == idx) return data_write;
        return m_regs[idx];
    endfunction

    function automatic bit exp_busy(input logic [4:0] idx, input bit byp);
        return m_busy[idx] && !(byp && reg_write && num_write == idx);
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("model_a_byp",   a1, exp_rd(rs, 1));
        check("model_b_byp",   b1, exp_rd(rt, 1));
        check("model_a_nob",   a0, exp_rd(rs, 0));
        check("model_b_nob",   b0, exp_rd(rt, 0));
        check("model_rsb_byp", 32'(rsb1), 32'(exp_busy(rs, 1)));
        check("model_rtb_byp", 32'(rtb1), 32'(exp_busy(rt, 1)));
        check("model_rsb_nob", 32'(rsb0), 32'(exp_busy(rs, 0)));
        check("model_rtb_nob", 32'(rtb0), 32'(exp_busy(rt, 0)));
        check("model_cnt_byp", 32'(cnt1), 32'(exp_cnt()));
        check("model_cnt_nob", 32'(cnt0), 32'(exp_cnt()));
    end

    task automatic drive(input bit rw, input logic [4:0] nw, input logic [31:0] dw,
                         input bit iv, input logic [4:0] ird,
                         input logic [4:0] s, input logic [4:0] t);
        reg_write = rw; num_write = nw; data_write = dw;
        issue_valid = iv; issue_rd = ird; rs = s; rt = t;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tick(); tick();
        check("rst_a", a1, 32'h0);
        check("rst_cnt", 32'(cnt1), 32'd0);
        reset = 1'b0;
        tick();

        drive(1, 5, 32'h1234_5678, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 5, 0); #1;
        check("r5_read", a1, 32'h1234_5678);

        drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0); #1;
        check("r0_wr_a", a1, 32'h0);
        check("r0_wr_b", b1, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("r0_after", a1, 32'h0);

        drive(1, 7, 32'h1111_0000, 1, 7, 0, 0); tick();
        drive(1, 7, 32'hA5A5_A5A5, 0, 0, 7, 7); #1;
        check("byp_a", a1, 32'hA5A5_A5A5);
        check("byp_b", b1, 32'hA5A5_A5A5);
        check("byp_rsb", 32'(rsb1), 32'd0);
        check("nob_a", a0, 32'h1111_0000);
        check("nob_rsb", 32'(rsb0), 32'd1);
        check("r7_cnt", 32'(cnt1), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 7, 0); #1;
        check("r7_clr_cnt", 32'(cnt1), 32'd0);
        check("r7_val", a0, 32'hA5A5_A5A5);

        drive(0, 0, 0, 1, 3, 0, 0); tick();
        drive(0, 0, 0, 1, 9, 0, 0); #1;
        check("iss3_cnt", 32'(cnt1), 32'd1);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        check("iss9_cnt", 32'(cnt1), 32'd2);
        tick();
        drive(0, 0, 0, 0, 0, 3, 0); #1;
        check("iss0_cnt", 32'(cnt1), 32'd2);
        check("r3_busy", 32'(rsb1), 32'd1);
        drive(1, 3, 32'h33, 0, 0, 3, 0); #1;
        check("r3_fwd_hide", 32'(rsb1), 32'd0);
        check("r3_nob_busy", 32'(rsb0), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 3, 0); #1;
        check("r3_wb_cnt", 32'(cnt1), 32'd1);
        check("r3_wb_rsb", 32'(rsb0), 32'd0);

        drive(1, 4, 32'h44, 1, 4, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 4, 0); #1;
        check("set_wins", 32'(rsb1), 32'd1);
        check("set_wins_cnt", 32'(cnt1), 32'd2);
        drive(1, 9, 32'h99, 1, 6, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 6, 9); #1;
        check("net0_cnt", 32'(cnt1), 32'd2);
        check("net0_r6", 32'(rsb1), 32'd1);
        check("net0_r9", 32'(rtb1), 32'd0);

        for (int i = 1; i < 32; i++) begin
            drive(0, 0, 0, 1, 5'(i), 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("full_cnt", 32'(cnt1), 32'd31);
        drive(0, 0, 0, 1, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 5, 0); #1;
        check("full_reissue", 32'(cnt1), 32'd31);
        check("r5_busy", 32'(rsb1), 32'd1);

        #2;
        drive(1, 5, 32'hDEAD_BEEF, 1, 2, 5, 4);
        reset = 1'b1;
        #1;
        check("arst_cnt", 32'(cnt1), 32'd0);
        check("arst_a", a1, 32'h0);
        check("arst_b", b0, 32'h0);
        check("arst_rsb", 32'(rsb1), 32'd0);
        tick();
        #2;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 5, 2); #1;
        check("post_rst_a", a1, 32'h0);
        check("post_rst_cnt", 32'(cnt1), 32'd0);
        check("post_rst_rtb", 32'(rtb1), 32'd0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
